// File: rtl/anton_ram_2port_clr_pkg.sv
// Shared defaults and clear-engine state type for the pixel-buffer RAM.
// Compile this file first; the macros below are visible to later files.
`ifndef ANTON_COMMON_VH
`define ANTON_COMMON_VH
`define BUFFER_END_DEFAULT 16
`define CLOG2(x) $clog2(x)
`define RAM_CLEAR_VALUE_DEFAULT 0
`endif

package anton_ram_2port_clr_pkg;

    localparam int unsigned BUFFER_END_DEFAULT      = `BUFFER_END_DEFAULT;
    localparam int unsigned RAM_CLEAR_VALUE_DEFAULT = `RAM_CLEAR_VALUE_DEFAULT;

    typedef enum logic {
        StIdle,
        StClearing
    } clr_state_e;

    // Address width able to encode BUFFER_END itself, so out-of-range values are representable.
    function automatic int unsigned addr_bits(input int unsigned depth);
        return `CLOG2(depth + 1);
    endfunction

    // Index width for the physical array (at least one bit).
    function automatic int unsigned idx_bits(input int unsigned depth);
        return (depth > 1) ? `CLOG2(depth) : 1;
    endfunction

endpackage

// File: rtl/anton_ram_clear_fsm.sv
// Clear engine: sweeps CLEAR_VALUE over the array after reset or on request and
// owns the RAM write port, muxing between the sweep and the user write.
module anton_ram_clear_fsm
    import anton_ram_2port_clr_pkg::*;
#(
    parameter int unsigned          BUFFER_END  = BUFFER_END_DEFAULT,
    parameter int unsigned          BUFFER_BITS = addr_bits(BUFFER_END),
    parameter int unsigned          DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clear,
    input  logic                   i_wr,
    input  logic [BUFFER_BITS-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]  i_din,
    output logic                   o_busy,
    output logic                   o_wr_int,
    output logic [BUFFER_BITS-1:0] o_waddr_int,
    output logic [DATA_WIDTH-1:0]  o_din_int
);

    localparam logic [BUFFER_BITS-1:0] LAST_ADDR = BUFFER_BITS'(BUFFER_END - 1);

    clr_state_e              r_state;
    clr_state_e              w_state_d;
    logic [BUFFER_BITS-1:0]  r_clr_addr;
    logic [BUFFER_BITS-1:0]  w_clr_addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StClearing;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_d;
            r_clr_addr <= w_clr_addr_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_clr_addr_d = r_clr_addr;
        unique case (r_state)
            StIdle: begin
                if (i_clear) begin
                    w_state_d    = StClearing;
                    w_clr_addr_d = '0;
                end
            end
            StClearing: begin
                // A new request restarts the sweep even on its final word.
                if (i_clear) begin
                    w_clr_addr_d = '0;
                end else if (r_clr_addr == LAST_ADDR) begin
                    w_state_d    = StIdle;
                    w_clr_addr_d = '0;
                end else begin
                    w_clr_addr_d = r_clr_addr + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        o_busy      = 1'b0;
        o_wr_int    = i_wr;
        o_waddr_int = i_waddr;
        o_din_int   = i_din;
        unique case (r_state)
            StIdle: begin
                o_busy = 1'b0;
            end
            StClearing: begin
                o_busy      = 1'b1;
                o_wr_int    = 1'b1;
                o_waddr_int = r_clr_addr;
                o_din_int   = CLEAR_VALUE;
            end
        endcase
    end

endmodule

// File: rtl/anton_ram_2port_clr.sv
// Simple dual-port pixel-buffer RAM with registered read, optional
// read-during-write bypass and a built-in clear sweep.
module anton_ram_2port_clr
    import anton_ram_2port_clr_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           BUFFER_END  = BUFFER_END_DEFAULT,
    parameter int unsigned           BYPASS      = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = DATA_WIDTH'(RAM_CLEAR_VALUE_DEFAULT),
    localparam int unsigned          BUFFER_BITS = addr_bits(BUFFER_END)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr,
    input  logic [BUFFER_BITS-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   rd,
    input  logic [BUFFER_BITS-1:0] raddr,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    input  logic                   clear,
    output logic                   busy
);

    localparam int unsigned            IDX_BITS = idx_bits(BUFFER_END);
    localparam logic [BUFFER_BITS-1:0] END_ADDR = BUFFER_BITS'(BUFFER_END);

    logic [DATA_WIDTH-1:0]  r_mem [BUFFER_END];
    logic [DATA_WIDTH-1:0]  r_dout;
    logic                   r_dout_valid;

    logic                   w_busy;
    logic                   w_wr_ok;
    logic                   w_rd_ok;
    logic                   w_raddr_ok;
    logic                   w_hit;
    logic                   w_wr_int;
    logic [BUFFER_BITS-1:0] w_waddr_int;
    logic [DATA_WIDTH-1:0]  w_din_int;
    logic [DATA_WIDTH-1:0]  w_rdata;

    assign w_wr_ok    = wr && (waddr < END_ADDR);
    assign w_raddr_ok = raddr < END_ADDR;
    assign w_rd_ok    = rd && !w_busy;
    assign w_hit      = (BYPASS != 0) && w_wr_ok && !w_busy && (waddr == raddr);

    anton_ram_clear_fsm #(
        .BUFFER_END  (BUFFER_END),
        .BUFFER_BITS (BUFFER_BITS),
        .DATA_WIDTH  (DATA_WIDTH),
        .CLEAR_VALUE (CLEAR_VALUE)
    ) u_clear_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (clear),
        .i_wr        (w_wr_ok),
        .i_waddr     (waddr),
        .i_din       (din),
        .o_busy      (w_busy),
        .o_wr_int    (w_wr_int),
        .o_waddr_int (w_waddr_int),
        .o_din_int   (w_din_int)
    );

    // The array is deliberately not reset; the sweep initialises it.
    always_ff @(posedge clk) begin
        if (w_wr_int) begin
            r_mem[w_waddr_int[IDX_BITS-1:0]] <= w_din_int;
        end
    end

    always_comb begin
        w_rdata = CLEAR_VALUE;
        if (w_raddr_ok) begin
            w_rdata = w_hit ? din : r_mem[raddr[IDX_BITS-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_dout <= w_rdata;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = w_busy;

endmodule

// File: tb/tb_anton_ram_2port_clr.sv
// Scoreboard bench: one DUT per bypass mode, shared random stimulus,
// array-level reference model, decoupled read monitors.
module tb_anton_ram_2port_clr;

    localparam int          BE  = 16;
    localparam int          AB  = 5;
    localparam logic [7:0]  CLV = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       clear = 1'b0;
    logic [AB-1:0] waddr = '0;
    logic [AB-1:0] raddr = '0;
    logic [7:0] din = '0;
    logic [7:0] dout1, dout0;
    logic       dv1, dv0, busy1, busy0;

    anton_ram_2port_clr #(
        .DATA_WIDTH (8), .BUFFER_END (BE), .BYPASS (1), .CLEAR_VALUE (CLV)
    ) dut1 (
        .clk (clk), .rst_n (rst_n), .wr (wr), .waddr (waddr), .din (din), .rd (rd),
        .raddr (raddr), .dout (dout1), .dout_valid (dv1), .clear (clear), .busy (busy1)
    );

    anton_ram_2port_clr #(
        .DATA_WIDTH (8), .BUFFER_END (BE), .BYPASS (0), .CLEAR_VALUE (CLV)
    ) dut0 (
        .clk (clk), .rst_n (rst_n), .wr (wr), .waddr (waddr), .din (din), .rd (rd),
        .raddr (raddr), .dout (dout0), .dout_valid (dv0), .clear (clear), .busy (busy0)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [7:0] d;
    } exp_t;

    exp_t       q1[$];
    exp_t       q0[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] last1 = 8'h00;
    logic [7:0] last0 = 8'h00;
    logic       exp_busy = 1'b1;
    logic [7:0] mdl [BE];
    int         left = BE;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic clear_mdl();
        for (int i = 0; i < BE; i++) mdl[i] = CLV;
    endtask

    // Monitors: sample 1 time unit after the active edge.
    always @(posedge clk) begin
        exp_t e1;
        exp_t e0;
        #1;
        chk("busy_p1", busy1, exp_busy);
        chk("busy_p0", busy0, exp_busy);
        if (dv1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL p1_unexpected_valid actual dout %0h required no read pending", dout1);
            end else begin
                e1 = q1.pop_front();
                chk("p1_latency", cyc, e1.c);
                chk("p1_data", dout1, e1.d);
                last1 = e1.d;
            end
        end else begin
            chk("p1_hold", dout1, last1);
        end
        if (dv0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL p0_unexpected_valid actual dout %0h required no read pending", dout0);
            end else begin
                e0 = q0.pop_front();
                chk("p0_latency", cyc, e0.c);
                chk("p0_data", dout0, e0.d);
                last0 = e0.d;
            end
        end else begin
            chk("p0_hold", dout0, last0);
        end
    end

    // One clock of stimulus; called at posedge+2, returns at the next posedge+2.
    task automatic step(input logic w, input int wa, input logic [7:0] d,
                        input logic r, input int ra, input logic c);
        exp_t x;
        wr = w; waddr = wa[AB-1:0]; din = d; rd = r; raddr = ra[AB-1:0]; clear = c;
        if (left > 0) begin
            if (c) begin
                left = BE;
                clear_mdl();
            end else begin
                left--;
            end
        end else begin
            if (r) begin
                x.c = cyc + 1;
                x.d = (ra >= BE) ? CLV : ((w && wa == ra) ? d : mdl[ra]);
                q1.push_back(x);
                x.d = (ra >= BE) ? CLV : mdl[ra];
                q0.push_back(x);
            end
            if (w && wa < BE) mdl[wa] = d;
            if (c) begin
                clear_mdl();
                left = BE;
            end
        end
        @(posedge clk);
        exp_busy = (left > 0);
        #2;
        wr = 1'b0; rd = 1'b0; clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 8'h00, 1'b0, 0, 1'b0);
    endtask

    task automatic read_all();
        for (int a = 0; a < BE; a++) step(1'b0, 0, 8'h00, 1'b1, a, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_dout_p1", dout1, 8'h00);
        chk("rst_valid_p1", dv1, 1'b0);
        chk("rst_busy_p1", busy1, 1'b1);
        chk("rst_dout_p0", dout0, 8'h00);
        chk("rst_valid_p0", dv0, 1'b0);
        q1.delete();
        q0.delete();
        last1 = 8'h00;
        last0 = 8'h00;
        exp_busy = 1'b1;
        left = BE;
        clear_mdl();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        clear_mdl();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        left = BE;
        exp_busy = 1'b1;

        // Sweep after reset, with rd held high to confirm it is ignored.
        for (int i = 0; i < BE; i++) step(1'b0, 0, 8'h00, 1'b1, i, 1'b0);
        read_all();
        idle(2);

        step(1'b1, 3, 8'hA5, 1'b0, 0, 1'b0);
        step(1'b0, 0, 8'h00, 1'b1, 3, 1'b0);
        idle(3);

        step(1'b1, 7, 8'h11, 1'b0, 0, 1'b0);
        step(1'b1, 7, 8'h3C, 1'b1, 7, 1'b0);
        step(1'b0, 0, 8'h00, 1'b1, 7, 1'b0);
        idle(1);

        // Fill, clear, hammer the user ports throughout the sweep.
        for (int a = 0; a < BE; a++) step(1'b1, a, 8'hFF, 1'b0, 0, 1'b0);
        step(1'b0, 0, 8'h00, 1'b0, 0, 1'b1);
        for (int i = 0; i < BE; i++)
            step(1'b1, $urandom_range(0, BE - 1), 8'hFF, 1'b1, $urandom_range(0, BE - 1), 1'b0);
        read_all();

        // Reset mid-sweep around clr_addr 9.
        for (int a = 0; a < BE; a++) step(1'b1, a, 8'(a * 7 + 1), 1'b0, 0, 1'b0);
        step(1'b0, 0, 8'h00, 1'b0, 0, 1'b1);
        idle(9);
        pulse_reset();
        idle(BE);
        read_all();

        // Out-of-range write and read.
        for (int a = 0; a < BE; a++) step(1'b1, a, 8'(a + 8'h40), 1'b0, 0, 1'b0);
        step(1'b1, BE, 8'hEE, 1'b0, 0, 1'b0);
        step(1'b0, 0, 8'h00, 1'b1, BE, 1'b0);
        read_all();

        // Random traffic, including clears during sweeps.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, BE + 1), 8'($urandom),
                 1'($urandom_range(0, 9) < 6), $urandom_range(0, BE + 1),
                 1'($urandom_range(0, 63) == 0));
        end
        idle(BE + 2);
        read_all();
        idle(2);

        chk("q1_drained", q1.size(), 0);
        chk("q0_drained", q0.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
